// File: rtl/uart_pkg.sv
// Shared UART constants and the transmitter state type.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    localparam int DATA_BITS        = 16;
    localparam int FRAME_BITS       = 18;        // start + 16 data + stop
    localparam int DEFAULT_CLK_FREQ = 27000000;

    // Baud counter width; terminal counts must fit below 2**BAUD_CNT_W.
    localparam int BAUD_CNT_W = 12;
    localparam int BIT_CNT_W  = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter with synchronous clear; pulses on terminal count.
// Latency: tick_o is combinational from the count register (baud_div+1 clocks per tick).
// Backpressure: none; the counter is held at zero while clear_i is high.
//
// Ports: clk_i/rst_ni clock and async active-low reset, clear_i holds the count
// at zero, tick_o is high in the cycle whose edge wraps the count to zero.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int baud_div = 2812
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_o
);

    localparam logic [BAUD_CNT_W-1:0] DIV = BAUD_CNT_W'(baud_div);

    logic [BAUD_CNT_W-1:0] cnt_q;
    logic [BAUD_CNT_W-1:0] cnt_d;

    always_comb begin
        if (clear_i || (cnt_q == DIV)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = !clear_i && (cnt_q == DIV);

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: 1 start, 16 data bits LSB first, 1 stop; one-word holding register.
// Latency: accept -> start-bit edge 1 clock; frame is 18*(baud_div+1) clocks.
// Backpressure: Tx_ready low while the holding register is full; Tx_valid is ignored then.
//
// Ports: clock/reset (async active-low), Tx_data/Tx_valid/Tx_ready word handshake,
// TxD registered serial line (idles high), Tx_busy frame active or word held,
// Tx_done one-cycle pulse at the end of each stop bit.
module uart_tx
    import uart_pkg::*;
#(
    parameter int clk_freq  = DEFAULT_CLK_FREQ,
    parameter int baud_rate = 9600,
    parameter int baud_div  = (clk_freq / baud_rate) - 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] Tx_data,
    input  logic                 Tx_valid,
    output logic                 Tx_ready,
    output logic                 TxD,
    output logic                 Tx_busy,
    output logic                 Tx_done
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_BITS - 1);

    tx_state_t state_q, state_d;

    logic [DATA_BITS-1:0] hold_q, hold_d;
    logic                 hold_full_q, hold_full_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic                 txd_q, txd_d;
    logic                 done_q, done_d;

    logic tick;
    logic accept;
    logic load;

    // Bit timing only advances while a frame is on the line.
    uart_baud_tick #(
        .baud_div(baud_div)
    ) u_baud (
        .clk_i  (clock),
        .rst_ni (reset),
        .clear_i(state_q == TX_IDLE),
        .tick_o (tick)
    );

    assign accept = Tx_valid && !hold_full_q;

    // The held word moves to the shifter either straight from idle or at the
    // end of a stop bit, which gives gap-free back-to-back frames.
    assign load = hold_full_q &&
                  ((state_q == TX_IDLE) || ((state_q == TX_STOP) && tick));

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= TX_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            TX_IDLE:  if (hold_full_q) state_d = TX_START;
            TX_START: if (tick) state_d = TX_DATA;
            TX_DATA:  if (tick && (bit_cnt_q == LAST_BIT)) state_d = TX_STOP;
            TX_STOP:  if (tick) state_d = hold_full_q ? TX_START : TX_IDLE;
            default:  state_d = TX_IDLE;
        endcase
    end

    // Output / datapath next-state logic
    always_comb begin
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        txd_d       = txd_q;
        done_d      = 1'b0;

        // accept and load never coincide: load needs a full register, accept an empty one.
        if (accept) begin
            hold_d      = Tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            TX_START: begin
                if (tick) begin
                    txd_d     = shift_q[0];
                    bit_cnt_d = '0;
                end
            end
            TX_DATA: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        txd_d = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        txd_d     = shift_q[1];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            TX_STOP: begin
                if (tick) begin
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            txd_d       = 1'b0;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            txd_q       <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            txd_q       <= txd_d;
            done_q      <= done_d;
        end
    end

    assign Tx_ready = !hold_full_q;
    assign TxD      = txd_q;
    assign Tx_done  = done_q;
    assign Tx_busy  = (state_q != TX_IDLE) || hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;
    import uart_pkg::*;

    localparam int BIT_CLKS   = 10;
    localparam int FRAME_CLKS = FRAME_BITS * BIT_CLKS;

    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic [15:0] Tx_data  = 16'h0;
    logic        Tx_valid = 1'b0;
    logic        Tx_ready;
    logic        TxD;
    logic        Tx_busy;
    logic        Tx_done;

    uart_tx #(
        .clk_freq (27000000),
        .baud_rate(2700000)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .Tx_data (Tx_data),
        .Tx_valid(Tx_valid),
        .Tx_ready(Tx_ready),
        .TxD     (TxD),
        .Tx_busy (Tx_busy),
        .Tx_done (Tx_done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------------------------------------------------------
    // Reference model: a line-level receiver. Every accepted word must
    // appear on TxD as {stop=1, word LSB first, start=0}, each level held
    // BIT_CLKS clocks, with Tx_done exactly at the end of the stop bit.
    // ---------------------------------------------------------------
    logic [15:0] exp_q[$];
    int          start_cyc[$];
    int          end_cyc[$];
    bit          mon_active = 0;
    int          mon_k = 0;
    logic [17:0] mon_frame = '0;
    logic [17:0] obs_frame = '0;
    int          bad_samples = 0;
    int          early_done = 0;
    int          frames_done = 0;
    int          done_pulses = 0;
    int          spurious_done = 0;
    int          unexpected_starts = 0;
    int          busy_err = 0;
    int          ready_err = 0;

    always @(negedge clock) begin
        if (!reset) begin
            mon_active = 0;
            exp_q.delete();
        end else begin
            if (Tx_done === 1'b1) done_pulses++;
            if (mon_active) begin
                mon_k++;
                if (mon_k < FRAME_CLKS) begin
                    if (TxD !== mon_frame[mon_k / BIT_CLKS]) bad_samples++;
                    if (Tx_done !== 1'b0) early_done++;
                    if (mon_k % BIT_CLKS == BIT_CLKS / 2) obs_frame[mon_k / BIT_CLKS] = TxD;
                end else begin
                    chk("frame_bits_bad_samples", bad_samples, 0);
                    chk("done_before_stop_end", early_done, 0);
                    chk("done_at_stop_end", {31'b0, Tx_done}, 1);
                    end_cyc.push_back(cyc);
                    frames_done++;
                    mon_active = 0;
                end
            end else if (Tx_done !== 1'b0) begin
                spurious_done++;
            end
            if (!mon_active && TxD === 1'b0) begin
                logic [15:0] w;
                w = 16'h0;
                if (exp_q.size() == 0) unexpected_starts++;
                else w = exp_q.pop_front();
                mon_frame   = {1'b1, w, 1'b0};
                obs_frame   = '0;
                mon_active  = 1;
                mon_k       = 0;
                bad_samples = 0;
                early_done  = 0;
                start_cyc.push_back(cyc);
            end
            if (Tx_busy !== (mon_active || exp_q.size() != 0)) busy_err++;
            if (Tx_ready !== (exp_q.size() == 0)) ready_err++;
            if (Tx_valid && Tx_ready) exp_q.push_back(Tx_data);
        end
    end

    // ---------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // ---------------------------------------------------------------
    logic [15:0] words[8];
    int          acc_cyc[8];

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present words[0..n-1] with Tx_valid held high throughout.
    task automatic send_list(input int n);
        for (int i = 0; i < n; i++) begin
            int t;
            t = 0;
            Tx_data  = words[i];
            Tx_valid = 1'b1;
            while (!Tx_ready && t < 1000) begin
                step();
                t++;
            end
            if (!Tx_ready) chk("accept_timeout_ready", {31'b0, Tx_ready}, 1);
            step();
            acc_cyc[i] = cyc;
        end
        Tx_valid = 1'b0;
        Tx_data  = 16'($urandom);
    endtask

    task automatic wait_frames(input int target);
        int t;
        t = 0;
        while (frames_done < target && t < 3000) begin
            step();
            t++;
        end
        chk("frame_wait_count", frames_done, target);
    endtask

    typedef struct {
        logic [15:0] data;
        logic [17:0] frame;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #20_000_000;
        $display("FAIL watchdog_timeout cycle=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int txd_bad, idle_done, ready_bad;

        // Expected line levels written out bit by bit: [0]=start ... [17]=stop.
        vecs[0] = '{16'hA5C3, 18'b1_1010010111000011_0};
        vecs[1] = '{16'h0001, 18'b1_0000000000000001_0};
        vecs[2] = '{16'h8000, 18'b1_1000000000000000_0};
        vecs[3] = '{16'h1234, 18'b1_0001001000110100_0};

        // Reset state
        step();
        step();
        chk("reset_txd", {31'b0, TxD}, 1);
        chk("reset_ready", {31'b0, Tx_ready}, 1);
        chk("reset_busy", {31'b0, Tx_busy}, 0);
        chk("reset_done", {31'b0, Tx_done}, 0);
        reset = 1'b1;

        // Idle: nothing presented for 1000 clocks
        txd_bad = 0; idle_done = 0; ready_bad = 0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (TxD !== 1'b1) txd_bad++;
            if (Tx_done !== 1'b0) idle_done++;
            if (Tx_ready !== 1'b1) ready_bad++;
        end
        chk("idle_txd_not_high", txd_bad, 0);
        chk("idle_done_pulses", idle_done, 0);
        chk("idle_ready_low", ready_bad, 0);

        // Table-driven single frames
        for (int v = 0; v < 4; v++) begin
            base = frames_done;
            words[0] = vecs[v].data;
            send_list(1);
            wait_frames(base + 1);
            chk($sformatf("tbl%0d_frame", v), {14'b0, obs_frame}, {14'b0, vecs[v].frame});
            chk($sformatf("tbl%0d_accept_to_start", v), start_cyc[$] - acc_cyc[0], 1);
            chk($sformatf("tbl%0d_start_to_done", v), end_cyc[$] - start_cyc[$], FRAME_CLKS);
        end

        // Back-to-back with Tx_valid held high
        base = frames_done;
        words[0] = 16'h0000;
        words[1] = 16'hFFFF;
        send_list(2);
        wait_frames(base + 2);
        chk("b2b_second_start_gap", start_cyc[base + 1] - start_cyc[base], FRAME_CLKS);
        chk("b2b_total_clocks", end_cyc[base + 1] - start_cyc[base], 2 * FRAME_CLKS);

        // Backpressure: three words presented continuously
        base = frames_done;
        for (int i = 0; i < 3; i++) words[i] = 16'($urandom);
        send_list(3);
        wait_frames(base + 3);
        chk("bp_second_accept", acc_cyc[1], start_cyc[base] + 1);
        chk("bp_third_accept_after_move", acc_cyc[2], start_cyc[base + 1] + 1);

        // Reset in the middle of a frame
        words[0] = 16'h1234;
        send_list(1);
        begin
            int t;
            t = 0;
            while (!(mon_active && mon_k >= 75) && t < 500) begin
                step();
                t++;
            end
            chk("rst_reached_mid_frame", mon_k, 75);
        end
        reset = 1'b0;
        #1;
        chk("rst_mid_txd", {31'b0, TxD}, 1);
        chk("rst_mid_busy", {31'b0, Tx_busy}, 0);
        chk("rst_mid_ready", {31'b0, Tx_ready}, 1);
        chk("rst_mid_done", {31'b0, Tx_done}, 0);
        step();
        step();
        reset = 1'b1;
        step();
        base = frames_done;
        words[0] = 16'h00FF;
        send_list(1);
        wait_frames(base + 1);
        chk("post_rst_frame", {14'b0, obs_frame}, {14'b0, 18'b1_0000000011111111_0});
        chk("post_rst_start_to_done", end_cyc[$] - start_cyc[$], FRAME_CLKS);

        // Randomized traffic: random words, random gaps (often mid-frame)
        base = frames_done;
        for (int i = 0; i < 24; i++) begin
            int gap;
            words[0] = 16'($urandom);
            words[1] = 16'($urandom);
            send_list(($urandom_range(0, 3) == 0) ? 2 : 1);
            gap = $urandom_range(0, 220);
            for (int g = 0; g < gap; g++) step();
        end
        begin
            int t;
            t = 0;
            while ((Tx_busy || mon_active) && t < 2000) begin
                step();
                t++;
            end
            chk("rand_drain_busy", {31'b0, Tx_busy}, 0);
        end
        for (int i = 0; i < 5; i++) step();

        chk("model_busy_mismatches", busy_err, 0);
        chk("model_ready_mismatches", ready_err, 0);
        chk("spurious_done_pulses", spurious_done, 0);
        chk("start_without_word", unexpected_starts, 0);
        chk("done_pulses_vs_frames", done_pulses, frames_done);
        chk("words_left_unsent", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
